// File: rtl/booth_mult_16bit.sv
// rtl/booth_mult_16bit.sv - sequential signed 16x16 radix-2 Booth multiplier (optional BOOTH_Q15_EN adds prod_q15)

// 16-bit adder/subtractor with signed overflow flag; the multiplier's only adder.
module addsub_16bit (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_sub,
  output logic [15:0] o_sum,
  output logic        o_ovfl
);

  logic [15:0] w_b_eff;

  // Invert the second operand and inject a carry to subtract.
  always_comb begin
    w_b_eff = i_b ^ {16{i_sub}};
    o_sum   = i_a + w_b_eff + {15'd0, i_sub};
    o_ovfl  = (i_a[15] == w_b_eff[15]) && (o_sum[15] != i_a[15]);
  end

endmodule

// Booth multiplier top. Build option: BOOTH_Q15_EN adds the saturated Q1.15 output.
module booth_mult_16bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_prod
`ifdef BOOTH_Q15_EN
  ,
  output logic [15:0] o_prod_q15
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [15:0] r_mcand;
  logic [15:0] r_hi;
  logic [15:0] r_lo;
  logic        r_qm1;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_prod;

  logic        w_load;
  logic        w_step;
  logic        w_finish;
  logic        w_busy_nxt;
  logic        w_done_nxt;

  logic [1:0]  w_booth;
  logic        w_add_en;
  logic        w_sub;
  logic [15:0] w_op_b;
  logic [15:0] w_sum;
  logic        w_ovfl;
  logic        w_sign;
  logic [31:0] w_prod_full;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: accept in IDLE, 16 Booth steps in RUN, one DONE cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == 4'd15) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: datapath controls and next values of the registered status flags.
  always_comb begin
    w_load     = (r_state == S_IDLE) && i_start;
    w_step     = (r_state == S_RUN);
    w_finish   = (r_state == S_DONE);
    w_busy_nxt = w_load || (r_state != S_IDLE);
    w_done_nxt = w_finish;
  end

  // Booth recoding: 01 adds, 10 subtracts, 00/11 add zero so hi passes through.
  always_comb begin
    w_booth  = {r_lo[0], r_qm1};
    w_add_en = w_booth[1] ^ w_booth[0];
    w_sub    = (w_booth == 2'b10);
    w_op_b   = w_add_en ? r_mcand : 16'd0;
  end

  addsub_16bit u_addsub (
    .i_a    (r_hi),
    .i_b    (w_op_b),
    .i_sub  (w_sub),
    .o_sum  (w_sum),
    .o_ovfl (w_ovfl)
  );

  // True 17th sign bit of the partial product; keeps mcand = -32768 exact.
  always_comb begin
    w_sign      = w_sum[15] ^ w_ovfl;
    w_prod_full = {r_hi, r_lo};
  end

  // Accumulator: load on accept, arithmetic shift of {sign, sum, lo, qm1} each step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand <= 16'd0;
      r_hi    <= 16'd0;
      r_lo    <= 16'd0;
      r_qm1   <= 1'b0;
      r_cnt   <= 4'd0;
    end else if (w_load) begin
      r_mcand <= i_a;
      r_hi    <= 16'd0;
      r_lo    <= i_b;
      r_qm1   <= 1'b0;
      r_cnt   <= 4'd0;
    end else if (w_step) begin
      r_hi    <= {w_sign, w_sum[15:1]};
      r_lo    <= {w_sum[0], r_lo[15:1]};
      r_qm1   <= r_lo[0];
      r_cnt   <= r_cnt + 4'd1;
    end
  end

  // Status flags and product register; prod changes only on the edge that raises done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_prod <= 32'd0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      if (w_finish) begin
        r_prod <= w_prod_full;
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_prod = r_prod;

`ifdef BOOTH_Q15_EN
  logic [15:0] r_prod_q15;
  logic [15:0] w_q15_nxt;

  // Q1.15 truncation, saturating when bits 31 and 30 disagree (only -1.0 * -1.0).
  always_comb begin
    if (w_prod_full[31] != w_prod_full[30]) begin
      w_q15_nxt = w_prod_full[31] ? 16'h8000 : 16'h7FFF;
    end else begin
      w_q15_nxt = w_prod_full[30:15];
    end
  end

  // Q15 output register, updated alongside prod.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod_q15 <= 16'd0;
    end else if (w_finish) begin
      r_prod_q15 <= w_q15_nxt;
    end
  end

  assign o_prod_q15 = r_prod_q15;
`endif

endmodule

// File: tb/tb_booth_mult_16bit.sv
// tb/tb_booth_mult_16bit.sv - scoreboard testbench for booth_mult_16bit
module tb_booth_mult_16bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [15:0] i_a = 16'd0;
  logic [15:0] i_b = 16'd0;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_prod;
`ifdef BOOTH_Q15_EN
  logic [15:0] o_prod_q15;
`endif

  booth_mult_16bit dut (
    .clk     (clk),
    .rst     (rst),
    .i_start (i_start),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_prod  (o_prod)
`ifdef BOOTH_Q15_EN
    ,
    .o_prod_q15 (o_prod_q15)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q_prod[$];
  int          q_cyc[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p;
  endfunction

  function automatic logic [15:0] ref_q15(input logic [31:0] p);
    if (p[31] != p[30]) return p[31] ? 16'h8000 : 16'h7FFF;
    return p[30:15];
  endfunction

  // Scoreboard monitor: pop expected product and completion cycle on every done.
  logic        prev_done = 1'b0;
  logic [31:0] m_exp;
  int          m_cyc;
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_done) check_eq("done_pulse", 32'(o_done), 32'd0);
      if (o_done) begin
        if (q_prod.size() == 0) begin
          check_eq("spurious_done", 32'(o_done), 32'd0);
        end else begin
          m_exp = q_prod.pop_front();
          m_cyc = q_cyc.pop_front();
          check_eq("prod", o_prod, m_exp);
          check_eq("latency", cyc, m_cyc + 17);
`ifdef BOOTH_Q15_EN
          check_eq("prod_q15", 32'(o_prod_q15), 32'(ref_q15(m_exp)));
`endif
        end
      end
      prev_done = o_done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while (q_prod.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q_prod.size() != 0) begin
      check_eq("timeout", q_prod.size(), 0);
      q_prod.delete();
      q_cyc.delete();
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    i_a = a;
    i_b = b;
    i_start = 1'b1;
    q_prod.push_back(ref_mul(a, b));
    q_cyc.push_back(cyc + 1);
    @(negedge clk);
    i_start = 1'b0;
    check_eq("busy_rise", 32'(o_busy), 32'd1);
    wait_idle(40);
  endtask

  int k;
  logic [15:0] ra, rb;
  logic [31:0] first_exp;

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(o_busy), 32'd0);
    check_eq("rst_done", 32'(o_done), 32'd0);
    check_eq("rst_prod", o_prod, 32'd0);
`ifdef BOOTH_Q15_EN
    check_eq("rst_q15", 32'(o_prod_q15), 32'd0);
`endif
    rst = 1'b0;

    // Basic multiply, then busy must drop the cycle after done.
    run_op(16'd3, 16'd5);
    check_eq("basic_value", o_prod, 32'h0000000F);
    @(negedge clk);
    check_eq("busy_fall", 32'(o_busy), 32'd0);
    check_eq("done_low", 32'(o_done), 32'd0);

    // Signed and extreme cases.
    run_op(16'hFFF9, 16'd6);
    check_eq("neg7x6", o_prod, 32'hFFFFFFD6);
    run_op(16'h7FFF, 16'h8000);
    check_eq("maxxmin", o_prod, 32'hC0008000);
    run_op(16'h8000, 16'h8000);
    check_eq("minxmin", o_prod, 32'h40000000);
`ifdef BOOTH_Q15_EN
    check_eq("minxmin_q15", 32'(o_prod_q15), 32'h00007FFF);
`endif
    run_op(16'h8000, 16'd1);
    check_eq("minx1", o_prod, 32'hFFFF8000);
    run_op(16'h7FFF, 16'h7FFF);
    run_op(16'h0000, 16'h8000);
    run_op(16'hFFFF, 16'hFFFF);
    run_op(16'h8000, 16'h7FFF);
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_op(ra, rb);
    end

    // Busy rejection: start held high, operands changed mid-run, back-to-back accept.
    @(negedge clk);
    i_a = 16'd1234;
    i_b = 16'hFFB3;
    i_start = 1'b1;
    k = cyc + 1;
    first_exp = ref_mul(16'd1234, 16'hFFB3);
    q_prod.push_back(first_exp);
    q_cyc.push_back(k);
    @(negedge clk);
    i_a = 16'h5555;
    i_b = 16'h7777;
    while (cyc < k + 17) @(negedge clk);
    i_a = 16'hFFFF;
    i_b = 16'h0100;
    q_prod.push_back(ref_mul(16'hFFFF, 16'h0100));
    q_cyc.push_back(k + 18);
    @(negedge clk);
    check_eq("b2b_busy", 32'(o_busy), 32'd1);
    repeat (3) @(negedge clk);
    i_start = 1'b0;
    i_a = 16'h1111;
    i_b = 16'h2222;
    check_eq("prod_hold", o_prod, first_exp);
    wait_idle(40);
    repeat (5) @(negedge clk);
    check_eq("prod_hold_idle", o_prod, 32'hFFFFFF00);

    // Reset in the middle of RUN.
    @(negedge clk);
    i_a = 16'd100;
    i_b = 16'd100;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst_busy", 32'(o_busy), 32'd0);
    check_eq("midrst_done", 32'(o_done), 32'd0);
    check_eq("midrst_prod", o_prod, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    check_eq("post_rst_prod", o_prod, 32'd0);
    run_op(16'd2, 16'hFFFE);
    check_eq("post_rst_op", o_prod, 32'hFFFFFFFC);

    repeat (3) @(negedge clk);
    check_eq("end_idle", 32'(o_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
